// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: lets two requesters take turns on one combinational
// MIPSALU + ALUControl pair. One operation is in flight at a time: accept,
// drive the ALU for one cycle, capture result/flags, hold the response until
// the owning requester takes it.
// Build option: define ALU_ARB_FIXED_PRIO_EN to make port 0 win every tie
// instead of alternating with round-robin.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [5:0]       req0_funct,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [5:0]       req1_funct,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_res,
  output logic             resp_zero,
  output logic             resp_ovf,
  output logic             resp_cout,
  output logic             resp_err,
  output logic [5:0]       alu_funct,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  input  logic             alu_cout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [5:0] FUNCT_NOOP = 6'h2C;

  state_t           state_q;
  logic             lastGrant_q;
  logic             owner_q;
  logic             isNoop_q;
  logic             isErr_q;
  logic [5:0]       aluFunct_q;
  logic [WIDTH-1:0] aluA_q;
  logic [WIDTH-1:0] aluB_q;
  logic             aluCin_q;
  logic [WIDTH-1:0] respRes_q;
  logic             respZero_q;
  logic             respOvf_q;
  logic             respCout_q;
  logic             respErr_q;
  logic             resp0Valid_q;
  logic             resp1Valid_q;

  logic             grant1_d;
  logic             accept_d;
  logic [5:0]       selFunct_d;
  logic [WIDTH-1:0] selA_d;
  logic [WIDTH-1:0] selB_d;
  logic             selCin_d;
  logic             selLegal_d;

  // Only the eight supported ALU operations are passed through to ALUControl.
  function automatic logic isLegalFunct(input logic [5:0] funct);
    case (funct)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2C: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  // Pick the winning port and mux its request fields toward the drive registers.
  always_comb begin
    grant1_d = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant1_d = req1_valid & ~req0_valid;
`else
    grant1_d = req1_valid & (~req0_valid | ~lastGrant_q);
`endif
    req0_ready = (state_q == IDLE) & req0_valid & ~grant1_d;
    req1_ready = (state_q == IDLE) & grant1_d;
    accept_d   = req0_ready | req1_ready;
    selFunct_d = grant1_d ? req1_funct : req0_funct;
    selA_d     = grant1_d ? req1_a     : req0_a;
    selB_d     = grant1_d ? req1_b     : req0_b;
    selCin_d   = grant1_d ? req1_cin   : req0_cin;
    selLegal_d = isLegalFunct(selFunct_d);
  end

  // Accept -> execute for one cycle -> hold response until the owner takes it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      lastGrant_q  <= 1'b1;
      owner_q      <= 1'b0;
      isNoop_q     <= 1'b0;
      isErr_q      <= 1'b0;
      aluFunct_q   <= FUNCT_NOOP;
      aluA_q       <= '0;
      aluB_q       <= '0;
      aluCin_q     <= 1'b0;
      respRes_q    <= '0;
      respZero_q   <= 1'b0;
      respOvf_q    <= 1'b0;
      respCout_q   <= 1'b0;
      respErr_q    <= 1'b0;
      resp0Valid_q <= 1'b0;
      resp1Valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            aluFunct_q  <= selLegal_d ? selFunct_d : FUNCT_NOOP;
            aluA_q      <= selA_d;
            aluB_q      <= selB_d;
            aluCin_q    <= selCin_d;
            isNoop_q    <= (selFunct_d == FUNCT_NOOP);
            isErr_q     <= ~selLegal_d;
            owner_q     <= grant1_d;
            lastGrant_q <= grant1_d;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          if (isNoop_q || isErr_q) begin
            respRes_q  <= '0;
            respZero_q <= 1'b0;
            respOvf_q  <= 1'b0;
            respCout_q <= 1'b0;
          end else begin
            respRes_q  <= alu_res;
            respZero_q <= alu_zero;
            respOvf_q  <= alu_ovf;
            respCout_q <= alu_cout;
          end
          respErr_q    <= isErr_q;
          resp0Valid_q <= ~owner_q;
          resp1Valid_q <= owner_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (owner_q ? resp1_ready : resp0_ready) begin
            resp0Valid_q <= 1'b0;
            resp1Valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_funct   = aluFunct_q;
  assign alu_a       = aluA_q;
  assign alu_b       = aluB_q;
  assign alu_cin     = aluCin_q;
  assign resp_res    = respRes_q;
  assign resp_zero   = respZero_q;
  assign resp_ovf    = respOvf_q;
  assign resp_cout   = respCout_q;
  assign resp_err    = respErr_q;
  assign resp0_valid = resp0Valid_q;
  assign resp1_valid = resp1Valid_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU stands in for MIPSALU,
// single-request vectors run from a table, multi-cycle corners by hand.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [5:0]  req0_funct;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [5:0]  req1_funct;
  logic [31:0] req1_a, req1_b;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp_res;
  logic        resp_zero, resp_ovf, resp_cout, resp_err;
  logic [5:0]  alu_funct;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_cin, alu_zero, alu_ovf, alu_cout;
  logic        busy;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic        port;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [5:0]  expFunct;
    logic [31:0] expRes;
    logic        expZero;
    logic        expOvf;
    logic        expCout;
    logic        expErr;
  } vec_t;

  vec_t vecs[11];
  logic expOrder[4];

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct(req0_funct),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct(req1_funct),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_res(resp_res), .resp_zero(resp_zero), .resp_ovf(resp_ovf),
    .resp_cout(resp_cout), .resp_err(resp_err),
    .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_cout(alu_cout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [32:0] aluSum;
  logic [31:0] aluDiff;

  // Behavioural MIPS ALU; NOOP returns junk with every flag set so sampling it is visible.
  always_comb begin
    aluSum   = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
    aluDiff  = alu_a - alu_b;
    alu_res  = 32'hDEADBEEF;
    alu_zero = 1'b1;
    alu_ovf  = 1'b1;
    alu_cout = 1'b1;
    if (alu_funct != 6'h2C) begin
      alu_ovf  = 1'b0;
      alu_cout = 1'b0;
      case (alu_funct)
        6'h20: begin
          alu_res  = aluSum[31:0];
          alu_cout = aluSum[32];
          alu_ovf  = (alu_a[31] == alu_b[31]) && (aluSum[31] != alu_a[31]);
        end
        6'h22: begin
          alu_res = aluDiff;
          alu_ovf = (alu_a[31] != alu_b[31]) && (aluDiff[31] != alu_a[31]);
        end
        6'h24:   alu_res = alu_a & alu_b;
        6'h25:   alu_res = alu_a | alu_b;
        6'h26:   alu_res = alu_a ^ alu_b;
        6'h27:   alu_res = ~(alu_a | alu_b);
        6'h2A:   alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
        default: alu_res = 32'hBADBAD00;
      endcase
      alu_zero = (alu_res == 32'd0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic clearRequests();
    req0_valid = 1'b0; req0_funct = 6'h00; req0_a = 32'd0; req0_b = 32'd0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_funct = 6'h00; req1_a = 32'd0; req1_b = 32'd0; req1_cin = 1'b0;
  endtask

  // One complete single-port transaction: accept, execute, respond, release.
  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    if (v.port) begin
      req1_valid = 1'b1; req1_funct = v.funct; req1_a = v.a; req1_b = v.b; req1_cin = v.cin;
    end else begin
      req0_valid = 1'b1; req0_funct = v.funct; req0_a = v.a; req0_b = v.b; req0_cin = v.cin;
    end
    #1;
    checkFlag({tag, ".ready"}, v.port ? req1_ready : req0_ready, 1'b1);
    checkFlag({tag, ".otherReady"}, v.port ? req0_ready : req1_ready, 1'b0);
    @(negedge clk);
    clearRequests();
    #1;
    checkFlag({tag, ".execNoResp"}, resp0_valid | resp1_valid, 1'b0);
    checkFlag({tag, ".execBusy"}, busy, 1'b1);
    checkOutput({tag, ".aluFunct"}, {26'd0, alu_funct}, {26'd0, v.expFunct});
    checkOutput({tag, ".aluA"}, alu_a, v.a);
    @(negedge clk);
    #1;
    checkFlag({tag, ".respValid"}, v.port ? resp1_valid : resp0_valid, 1'b1);
    checkFlag({tag, ".otherRespValid"}, v.port ? resp0_valid : resp1_valid, 1'b0);
    checkOutput({tag, ".res"}, resp_res, v.expRes);
    checkFlag({tag, ".zero"}, resp_zero, v.expZero);
    checkFlag({tag, ".ovf"}, resp_ovf, v.expOvf);
    checkFlag({tag, ".cout"}, resp_cout, v.expCout);
    checkFlag({tag, ".err"}, resp_err, v.expErr);
    if (v.port) resp1_ready = 1'b1; else resp0_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    #1;
    checkFlag({tag, ".idleAfter"}, busy, 1'b0);
    checkFlag({tag, ".respDropped"}, resp0_valid | resp1_valid, 1'b0);
    checkOutput({tag, ".aluFunctHeld"}, {26'd0, alu_funct}, {26'd0, v.expFunct});
  endtask

  // Both ports request continuously; grant order must follow the arbitration policy.
  task automatic runTieSequence();
    logic got;
    @(negedge clk);
    req0_valid = 1'b1; req0_funct = 6'h22; req0_a = 32'd3;    req0_b = 32'd3;    req0_cin = 1'b0;
    req1_valid = 1'b1; req1_funct = 6'h25; req1_a = 32'hF0; req1_b = 32'h0F; req1_cin = 1'b0;
    for (int t = 0; t < 4; t++) begin
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        #1;
        if (req0_ready | req1_ready) got = 1'b1;
        else @(negedge clk);
      end
      checkFlag($sformatf("tie%0d.granted", t), got, 1'b1);
      if (!got) break;
      checkFlag($sformatf("tie%0d.port", t), req1_ready, expOrder[t]);
      checkFlag($sformatf("tie%0d.exclusive", t), req0_ready & req1_ready, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #1;
      checkFlag($sformatf("tie%0d.respValid", t), expOrder[t] ? resp1_valid : resp0_valid, 1'b1);
      checkFlag($sformatf("tie%0d.otherResp", t), expOrder[t] ? resp0_valid : resp1_valid, 1'b0);
      checkOutput($sformatf("tie%0d.res", t), resp_res, expOrder[t] ? 32'hFF : 32'd0);
      checkFlag($sformatf("tie%0d.zero", t), resp_zero, ~expOrder[t]);
      if (expOrder[t]) resp1_ready = 1'b1; else resp0_ready = 1'b1;
      @(negedge clk);
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;
    end
    clearRequests();
  endtask

  // Overflowing add on port 1 with the response stalled while port 0 waits.
  task automatic runHoldSequence();
    @(negedge clk);
    req1_valid = 1'b1; req1_funct = 6'h20; req1_a = 32'h7FFFFFFF; req1_b = 32'd1; req1_cin = 1'b0;
    #1;
    checkFlag("hold.accept", req1_ready, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_funct = 6'h24; req0_a = 32'hF; req0_b = 32'h3; req0_cin = 1'b0;
    #1;
    checkFlag("hold.execReady0", req0_ready, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkFlag($sformatf("hold%0d.valid", i), resp1_valid, 1'b1);
      checkOutput($sformatf("hold%0d.res", i), resp_res, 32'h80000000);
      checkFlag($sformatf("hold%0d.ovf", i), resp_ovf, 1'b1);
      checkFlag($sformatf("hold%0d.busy", i), busy, 1'b1);
      checkFlag($sformatf("hold%0d.ready0", i), req0_ready, 1'b0);
      checkFlag($sformatf("hold%0d.resp0", i), resp0_valid, 1'b0);
      @(negedge clk);
    end
    resp1_ready = 1'b1;
    @(negedge clk);
    resp1_ready = 1'b0;
    #1;
    checkFlag("hold.idleAfter", busy, 1'b0);
    checkFlag("hold.waiterReady", req0_ready, 1'b1);
    @(negedge clk);
    clearRequests();
    @(negedge clk);
    #1;
    checkFlag("hold.waiterResp", resp0_valid, 1'b1);
    checkOutput("hold.waiterRes", resp_res, 32'h3);
    resp0_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
  endtask

  // Reset pulse while a response is pending must discard it entirely.
  task automatic runResetSequence();
    @(negedge clk);
    req0_valid = 1'b1; req0_funct = 6'h20; req0_a = 32'd5; req0_b = 32'd7; req0_cin = 1'b0;
    @(negedge clk);
    clearRequests();
    @(negedge clk);
    #1;
    checkFlag("rst.pendingValid", resp0_valid, 1'b1);
    checkOutput("rst.pendingRes", resp_res, 32'd12);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkFlag("rst.valid", resp0_valid, 1'b0);
    checkFlag("rst.busy", busy, 1'b0);
    checkOutput("rst.aluFunct", {26'd0, alu_funct}, 32'h2C);
    checkOutput("rst.res", resp_res, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checkFlag($sformatf("rst%0d.noResp", i), resp0_valid | resp1_valid, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 6'h20, 32'd5,         32'd7,         1'b1, 6'h20, 32'd13,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 6'h20, 32'h7FFFFFFF,  32'd1,         1'b0, 6'h20, 32'h80000000,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 6'h3F, 32'd4,         32'd4,         1'b0, 6'h2C, 32'd0,         1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 6'h2A, 32'd2,         32'd9,         1'b0, 6'h2A, 32'd1,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 6'h2C, 32'd5,         32'd5,         1'b0, 6'h2C, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 6'h24, 32'hFF00FF00,  32'h0F0F0F0F,  1'b0, 6'h24, 32'h0F000F00,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 6'h26, 32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 6'h26, 32'd0,         1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 6'h27, 32'd0,         32'd0,         1'b0, 6'h27, 32'hFFFFFFFF,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 6'h20, 32'hFFFFFFFF,  32'd1,         1'b0, 6'h20, 32'd0,         1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 6'h22, 32'd0,         32'd1,         1'b0, 6'h22, 32'hFFFFFFFF,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 6'h25, 32'd0,         32'd0,         1'b1, 6'h25, 32'd0,         1'b1, 1'b0, 1'b0, 1'b0};
`ifdef ALU_ARB_FIXED_PRIO_EN
    expOrder[0] = 1'b0; expOrder[1] = 1'b0; expOrder[2] = 1'b0; expOrder[3] = 1'b0;
`else
    expOrder[0] = 1'b0; expOrder[1] = 1'b1; expOrder[2] = 1'b0; expOrder[3] = 1'b1;
`endif

    reset_n     = 1'b0;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    clearRequests();
    repeat (2) @(negedge clk);
    #1;
    checkFlag("reset.resp0Valid", resp0_valid, 1'b0);
    checkFlag("reset.resp1Valid", resp1_valid, 1'b0);
    checkOutput("reset.res", resp_res, 32'd0);
    checkFlag("reset.flags", resp_zero | resp_ovf | resp_cout | resp_err, 1'b0);
    checkOutput("reset.aluA", alu_a, 32'd0);
    checkOutput("reset.aluB", alu_b, 32'd0);
    checkFlag("reset.aluCin", alu_cin, 1'b0);
    checkOutput("reset.aluFunct", {26'd0, alu_funct}, 32'h2C);
    checkFlag("reset.busy", busy, 1'b0);
    reset_n = 1'b1;

    runTieSequence();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end
    runHoldSequence();
    runResetSequence();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
